pipe_stage_skid: RTL and testbench

//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready

---
 rtl/pipe_pkg.sv | 16 +
 rtl/sat_counter.sv | 15 +
 rtl/pipe_stage_skid.sv | 98 +++++++++
 tb/tb_pipe_stage_skid.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage-register state encodings and per-stage payload/control widths.
package pipe_pkg;
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } ps_e;
    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_DATA_W  = 165;
    localparam int IDEX_CTRL_W  = 10;
    localparam int EXMEM_DATA_W = 133;
    localparam int EXMEM_CTRL_W = 8;
    localparam int MEMWB_DATA_W = 69;
    localparam int MEMWB_CTRL_W = 3;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones; synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else q <= clr ? '0 : (en && q != '1) ? q + 1'b1 : q;
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with optional 2-entry skid buffer,
// flush, and control bits gated to zero whenever the slot holds no valid instruction.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 133,
    parameter int CTRL_W   = 8,
    parameter int SKID_EN  = 1,
    parameter int ZERO_DAT = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);
    ps_e               state, state_nxt;
    logic              acc, dep, ld_main, ld_skid, promote;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    assign out_valid = state != PS_EMPTY;
    // With the skid buffer, in_ready comes straight from the state register.
    assign in_ready  = (SKID_EN != 0) ? (state != PS_SKID) : (!out_valid || out_ready);
    assign acc       = in_valid && in_ready;
    assign dep       = out_valid && out_ready;
    assign occ       = state;

    always_comb begin
        state_nxt = state;
        ld_main   = 1'b0;
        ld_skid   = 1'b0;
        promote   = 1'b0;
        if (flush) state_nxt = PS_EMPTY;
        else begin
            case (state)
                PS_EMPTY: if (acc) begin
                    state_nxt = PS_FULL;
                    ld_main   = 1'b1;
                end
                PS_FULL: if (acc && dep) ld_main = 1'b1;
                else if (dep) state_nxt = PS_EMPTY;
                else if (acc && SKID_EN != 0) begin
                    state_nxt = PS_SKID;
                    ld_skid   = 1'b1;
                end
                PS_SKID: if (dep) begin
                    state_nxt = PS_FULL;
                    promote   = 1'b1;
                end
                default: state_nxt = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PS_EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state <= state_nxt;
            if (ld_main) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (promote) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (ld_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign out_data = (ZERO_DAT != 0 && !out_valid) ? '0 : main_data;

    sat_counter #(.W(CNT_W)) u_stall (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (out_valid && !out_ready),
        .clr  (1'b0),
        .q    (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of a skid build (CNT_W=4) and a SKID_EN=0 build.
module tb_pipe_stage_skid;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, b_in_ready, b_out_valid;
    logic [7:0]  out_ctrl, b_out_ctrl;
    logic [15:0] out_data, b_out_data;
    logic [1:0]  occ, b_occ;
    logic [3:0]  stall_cnt, b_stall_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(16), .CTRL_W(8), .SKID_EN(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .occ(occ), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.DATA_W(16), .CTRL_W(8), .SKID_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occ(b_occ), .stall_cnt(b_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [15:0] d, input logic r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occ", occ, 0);
        check("rst_stall", stall_cnt, 0);
        tick;
        rst_n = 1'b1;
        tick;

        for (int i = 1; i <= 8; i++) begin
            drive(1, 8'(i + 8'h10), 16'(i), 1);
            tick;
            check($sformatf("stream_valid%0d", i), out_valid, 1);
            check($sformatf("stream_data%0d", i), out_data, i);
            check($sformatf("stream_ctrl%0d", i), out_ctrl, i + 8'h10);
            check($sformatf("stream_ready%0d", i), in_ready, 1);
        end
        drive(0, 8'h00, 16'h0, 1);
        tick;
        check("stream_drain_valid", out_valid, 0);
        check("stream_stall", stall_cnt, 0);

        drive(1, 8'h01, 16'h000A, 0);
        tick;
        drive(1, 8'h02, 16'h000B, 0);
        tick;
        check("bp_occ2", occ, 2);
        check("bp_in_ready0", in_ready, 0);
        drive(0, 8'h00, 16'h0, 0);
        tick;
        tick;
        check("bp_stall3", stall_cnt, 3);
        check("bp_hold_occ", occ, 2);
        check("bp_head_A", out_data, 16'h000A);
        check("bp_head_ctrlA", out_ctrl, 8'h01);
        out_ready = 1'b1;
        tick;
        check("bp_second_B", out_data, 16'h000B);
        check("bp_occ1", occ, 1);
        check("bp_ready_back", in_ready, 1);
        tick;
        check("bp_empty", occ, 0);
        check("bp_stall_kept", stall_cnt, 3);

        drive(1, 8'h03, 16'h000D, 0);
        tick;
        drive(1, 8'h04, 16'h000E, 0);
        tick;
        check("fl_pre_occ", occ, 2);
        flush = 1'b1;
        drive(1, 8'h5A, 16'h000C, 0);
        tick;
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ctrl", out_ctrl, 0);
        check("fl_occ", occ, 0);
        check("fl_data_hold", out_data, 16'h000D);
        check("fl_stall", stall_cnt, 5);
        drive(0, 8'h00, 16'h0, 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            check($sformatf("fl_noC%0d", i), out_valid, 0);
        end

        drive(1, 8'hFF, 16'h0077, 1);
        tick;
        check("bub_ctrl_ff", out_ctrl, 8'hFF);
        check("bub_data", out_data, 16'h0077);
        in_valid = 1'b0;
        in_ctrl  = 'x;
        in_data  = 'x;
        tick;
        check("bub_ctrl_0", out_ctrl, 8'h00);
        check("bub_valid_0", out_valid, 0);
        tick;
        check("bub_x_blocked", out_ctrl, 8'h00);

        drive(1, 8'h06, 16'h0031, 0);
        tick;
        drive(1, 8'h07, 16'h0032, 0);
        tick;
        check("ar_pre_occ", occ, 2);
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_ctrl", out_ctrl, 0);
        check("ar_occ", occ, 0);
        check("ar_in_ready", in_ready, 1);
        check("ar_stall", stall_cnt, 0);
        drive(0, 8'h00, 16'h0, 0);
        tick;
        rst_n = 1'b1;
        tick;
        check("ar_after_valid", out_valid, 0);

        drive(1, 8'h08, 16'h0040, 0);
        tick;
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (i == 14) check("sat_14", stall_cnt, 14);
            if (i == 16) check("sat_16", stall_cnt, 15);
        end
        check("sat_20", stall_cnt, 15);
        check("sat_occ", occ, 1);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick;
        drive(1, 8'h09, 16'h0021, 0);
        #1;
        check("ns_ready_empty", b_in_ready, 1);
        tick;
        check("ns_occ1", b_occ, 1);
        check("ns_ready_stall", b_in_ready, 0);
        check("ns_data21", b_out_data, 16'h0021);
        out_ready = 1'b1;
        #1;
        check("ns_ready_comb", b_in_ready, 1);
        in_data = 16'h0022;
        tick;
        check("ns_data22", b_out_data, 16'h0022);
        check("ns_occ_still1", b_occ, 1);
        drive(1, 8'h0A, 16'h0023, 0);
        tick;
        check("ns_hold22", b_out_data, 16'h0022);
        check("ns_occ_max1", b_occ, 1);
        check("ns_ready_low", b_in_ready, 0);
        check("ns_stall", b_stall_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
